// File: rtl/mem_ctrl_nport_pkg.sv
// Shared constants, FSM encoding and sizing helpers
// for the N-channel byte-serial memory controller.
package mem_ctrl_nport_pkg;

  localparam logic [1:0] IO_BASE_HI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int len_w(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_ctrl_nport_rr_arbiter.sv
// Combinational round-robin arbiter: first requester
// at or after ptr, wrapping modulo N.
module mem_ctrl_nport_rr_arbiter
  import mem_ctrl_nport_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : arb
    int c;
    c = 0;
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 0; off < N; off++) begin
      c = (int'(ptr) + off) % N;
      if (!any && req[c]) begin
        any = 1'b1;
        idx = IW'(c);
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_nport.sv
// N-channel byte-serial RAM/IO controller with
// round-robin arbitration, rollback and IO throttling.
module mem_ctrl_nport
  import mem_ctrl_nport_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int MAX_BYTES = 64,
  parameter int LEN_W     = len_w(MAX_BYTES),
  parameter logic [NUM_CH-1:0] RB_MASK = NUM_CH'(3'b011)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic [NUM_CH-1:0]       ch_req,
  input  logic [NUM_CH-1:0]       ch_wr,
  input  logic [NUM_CH*32-1:0]    ch_addr,
  input  logic [NUM_CH*LEN_W-1:0] ch_len,
  input  logic [NUM_CH*32-1:0]    ch_wdata,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [MAX_BYTES*8-1:0]  rdata
);

  localparam int IW = idx_w(NUM_CH);
  localparam int RW = MAX_BYTES * 8;

  state_t state, state_nx;

  logic [IW-1:0]     rr_ptr;
  logic [NUM_CH-1:0] g_oh;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       a_last;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  iss;
  logic [LEN_W-1:0]  rcv;
  logic              wr_r;
  logic              pend;
  logic              gap;
  logic              rdy_q;
  logic [RW-1:0]     rdata_r;

  logic [NUM_CH-1:0] req_eff;
  logic [NUM_CH-1:0] gnt;
  logic [IW-1:0]     gidx;
  logic              any;
  logic [LEN_W-1:0]  len_sel;
  logic [LEN_W-1:0]  iss_eff;

  logic resume;
  logic pend_eff;
  logic is_io;
  logic abort;
  logic rd_issue;
  logic rd_cap;
  logic rd_last;
  logic wr_fire;
  logic wr_last;
  logic gap_end;

  assign req_eff = ch_req & ~(rollback ? RB_MASK : '0);

  mem_ctrl_nport_rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_arb (
    .req   (req_eff),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gidx),
    .any   (any)
  );

  assign len_sel = ch_len[gidx*LEN_W +: LEN_W];

  // After a pause the in-flight read byte was dropped,
  // so issue resumes from the first byte not yet received.
  assign resume   = rdy && !rdy_q;
  assign iss_eff  = (resume && !wr_r) ? rcv : iss;
  assign pend_eff = pend && !resume;

  assign is_io = (addr_r[17:16] == IO_BASE_HI);
  assign abort = rollback && !wr_r && |(RB_MASK & g_oh);

  assign rd_issue = (state == ST_RUN) && !wr_r
                    && (iss_eff < len_r);
  assign rd_cap   = (state == ST_RUN) && !wr_r && pend_eff;
  assign rd_last  = rd_cap && (rcv + 1'b1 == len_r);

  assign wr_fire = (state == ST_RUN) && wr_r && !gap
                   && !(is_io && io_buffer_full)
                   && (iss < len_r);
  assign wr_last = wr_fire && (iss + 1'b1 == len_r);
  assign gap_end = (state == ST_RUN) && wr_r && gap
                   && (iss == len_r);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rdy) begin
      unique case (state)
        ST_IDLE: begin
          if (any)
            state_nx = (len_sel == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (abort)
            state_nx = ST_IDLE;
          else if (rd_last || (wr_last && !is_io) || gap_end)
            state_nx = ST_DONE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wr  = 1'b0;
    mem_a   = a_last;
    ch_done = '0;
    if (!rst && rdy) begin
      mem_wr = wr_fire;
      if (wr_fire || rd_issue)
        mem_a = addr_r + 32'(iss_eff);
      if (state == ST_DONE && !abort)
        ch_done = g_oh;
    end
  end

  assign mem_dout = wdata_r[8*iss[1:0] +: 8];
  assign rdata    = rdata_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      g_oh    <= '0;
      addr_r  <= '0;
      len_r   <= '0;
      wr_r    <= 1'b0;
      wdata_r <= '0;
      iss     <= '0;
      rcv     <= '0;
      pend    <= 1'b0;
      gap     <= 1'b0;
      rdy_q   <= 1'b1;
      a_last  <= '0;
      rdata_r <= '0;
    end else begin
      rdy_q <= rdy;
      if (rdy) begin
        a_last <= mem_a;
        if (state == ST_IDLE && any) begin
          g_oh    <= gnt;
          rr_ptr  <= (gidx == IW'(NUM_CH - 1)) ? '0
                     : gidx + 1'b1;
          addr_r  <= ch_addr[gidx*32 +: 32];
          len_r   <= len_sel;
          wr_r    <= ch_wr[gidx];
          wdata_r <= ch_wdata[gidx*32 +: 32];
          iss     <= '0;
          rcv     <= '0;
          pend    <= 1'b0;
          gap     <= 1'b0;
          rdata_r <= '0;
        end else if (state == ST_RUN) begin
          if (wr_r) begin
            if (wr_fire) begin
              iss <= iss + 1'b1;
              gap <= is_io;
            end else if (gap) begin
              gap <= 1'b0;
            end
          end else begin
            iss  <= rd_issue ? iss_eff + 1'b1 : iss_eff;
            pend <= rd_issue;
            if (rd_cap) begin
              rdata_r[8*rcv +: 8] <= mem_din;
              rcv <= rcv + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
